// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset address and entry layout for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int unsigned IF_ADDR_WIDTH = 32;
  localparam int unsigned INST_WIDTH    = 32;

  localparam logic [IF_ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [IF_ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0]    inst;
  } fq_entry_t;

  // Sequential word fetch; wraps modulo 2^32.
  function automatic logic [IF_ADDR_WIDTH-1:0] next_pc(input logic [IF_ADDR_WIDTH-1:0] pc);
    return pc + IF_ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Redirect, instruction-memory and decode-side handshake bundle for the fetch queue.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic                     redirect;
  logic [IF_ADDR_WIDTH-1:0] redirect_pc;

  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [IF_ADDR_WIDTH-1:0] imem_req_addr;
  logic                     imem_rsp_valid;
  logic [INST_WIDTH-1:0]    imem_rsp_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [INST_WIDTH-1:0]    out_inst;
  logic [IF_ADDR_WIDTH-1:0] out_pc;

  // Fetch-queue side.
  modport master (
    input  redirect, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_inst, out_pc
  );

  // Environment side: memory, decode and branch resolution.
  modport slave (
    output redirect, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_inst, out_pc
  );

endinterface

// File: rtl/fq_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is read combinationally.
module fq_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] slot_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointer and occupancy update; flush discards everything stored.
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) slot_mem[wr_ptr_q] <= push_data;
  end

  assign head_data = slot_mem[rd_ptr_q];
  assign count     = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && (count_q == CNT_W'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && (count_q == '0)));

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: credit-limited imem requests, in-order response
// buffering with PC pairing, and redirect flush that drops responses still owed.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned              DEPTH    = 4,
  parameter logic [IF_ADDR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = $bits(fq_entry_t);

  logic [IF_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
  fq_entry_t                last_head_q, last_head_d;

  logic [CNT_W-1:0]         q_count;
  logic [CNT_W-1:0]         inflight;
  fq_entry_t                q_head;
  fq_entry_t                q_push_data;
  logic [IF_ADDR_WIDTH-1:0] rsp_pc;

  logic credit_ok;
  logic req_valid;
  logic req_fire;
  logic out_valid;
  logic pop;
  logic rsp_keep;

  // Credit, drop and fetch-PC bookkeeping.
  always_comb begin
    credit_ok   = (SUM_W'(q_count) + SUM_W'(inflight)) < SUM_W'(DEPTH);
    req_valid   = !rst && !bus.redirect && credit_ok;
    req_fire    = req_valid && bus.imem_req_ready;
    out_valid   = (q_count != '0) && !bus.redirect;
    pop         = out_valid && bus.out_ready;
    rsp_keep    = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect;
    q_push_data = '{pc: rsp_pc, inst: bus.imem_rsp_data};

    fetch_pc_d  = fetch_pc_q;
    drop_cnt_d  = drop_cnt_q;
    last_head_d = last_head_q;

    if (q_count != '0) last_head_d = q_head;

    // Everything still owed after a redirect cycle belongs to the old stream.
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      drop_cnt_d = inflight - CNT_W'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = next_pc(fetch_pc_q);
      if (bus.imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      drop_cnt_q  <= '0;
      last_head_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      drop_cnt_q  <= drop_cnt_d;
      last_head_q <= last_head_d;
    end
  end

  // Instruction + PC queue presented to decode.
  fq_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (rsp_keep),
    .push_data (q_push_data),
    .pop       (pop),
    .head_data (q_head),
    .count     (q_count)
  );

  // PCs of accepted requests; survives redirects so late responses still pair up.
  fq_fifo #(
    .WIDTH (IF_ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (bus.imem_rsp_valid),
    .head_data (rsp_pc),
    .count     (inflight)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_inst       = (q_count != '0) ? q_head.inst : last_head_q.inst;
  assign bus.out_pc         = (q_count != '0) ? q_head.pc   : last_head_q.pc;

  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (inflight != '0));
  a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
    drop_cnt_q <= inflight);
  a_credit_bounded: assert property (@(posedge clk) disable iff (rst)
    (SUM_W'(q_count) + SUM_W'(inflight)) <= SUM_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue with a queue-based reference model and an in-order memory.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; }         infl_t;
  typedef struct { logic [31:0] addr; int due; }         mreq_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  logic [31:0] m_fpc = RPC;
  ent_t        m_q[$];
  infl_t       m_infl[$];

  // Memory model state
  mreq_t mem_q[$];
  bit    mem_hold = 1'b0;
  int    mem_lat_max = 0;
  int    rsp_pct = 100;

  // Stimulus controls
  bit          s_rst = 1'b1, s_redir = 1'b0, s_ready = 1'b0, s_oready = 1'b0;
  logic [31:0] s_rpc = '0;

  // Observed DUT handshakes
  logic [31:0] dut_fired[$];
  logic [31:0] dut_popped[$];
  int          pops_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [31:0] q[$], input int idx, input logic [31:0] exp);
    n_checks++;
    if (q.size() <= idx) begin
      n_fail++;
      $display("FAIL %s: only %0d entries recorded, expected %h at index %0d", name, q.size(), exp, idx);
    end else if (q[idx] !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, q[idx], exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare, advance memory and model.
  task automatic step();
    bit          rsp;
    logic [31:0] rdata;
    logic        exp_rv, exp_ov;
    bit          fire, pop;
    infl_t       e;
    @(negedge clk);
    rst                = s_rst;
    bus.redirect       = s_redir;
    bus.redirect_pc    = s_rpc;
    bus.imem_req_ready = s_ready;
    bus.out_ready      = s_oready;
    rsp   = 1'b0;
    rdata = '0;
    if (!s_rst && !mem_hold && mem_q.size() != 0 && mem_q[0].due <= cyc &&
        ($urandom_range(99) < rsp_pct)) begin
      rsp   = 1'b1;
      rdata = mem_word(mem_q[0].addr);
    end
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? rdata : $urandom();
    #1;
    exp_rv = !s_rst && !s_redir && (m_q.size() + m_infl.size() < DEPTH);
    exp_ov = (m_q.size() != 0) && !s_redir;
    check1("imem_req_valid", bus.imem_req_valid, exp_rv);
    check32("imem_req_addr", bus.imem_req_addr, m_fpc);
    check1("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) begin
      check32("out_pc", bus.out_pc, m_q[0].pc);
      check32("out_inst", bus.out_inst, m_q[0].inst);
    end

    if (bus.imem_req_valid === 1'b1 && s_ready) dut_fired.push_back(bus.imem_req_addr);
    if (bus.out_valid === 1'b1 && s_oready) begin
      dut_popped.push_back(bus.out_pc);
      pops_seen++;
    end

    if (s_rst) mem_q.delete();
    else begin
      if (rsp) void'(mem_q.pop_front());
      if (bus.imem_req_valid === 1'b1 && s_ready)
        mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + 1 + int'($urandom_range(mem_lat_max))});
    end

    fire = exp_rv && s_ready;
    pop  = exp_ov && s_oready;
    if (s_rst) begin
      m_fpc = RPC;
      m_q.delete();
      m_infl.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rsp) begin
        n_checks++;
        if (m_infl.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_pairing @cyc %0d: response with no model request outstanding", cyc);
        end else begin
          e = m_infl.pop_front();
          if (!e.stale && !s_redir) m_q.push_back('{pc: e.pc, inst: rdata});
        end
      end
      if (s_redir) begin
        m_q.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
        m_fpc = s_rpc;
      end else if (fire) begin
        m_infl.push_back('{pc: m_fpc, stale: 1'b0});
        m_fpc = m_fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    s_rst = 1'b1; s_redir = 1'b0;
    step();
    s_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] frozen_pc;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.imem_req_ready = 1'b0;
    bus.out_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;

    // Reset, then fill credits with responses withheld
    s_rst = 1'b1; run(2);
    s_rst = 1'b0; s_ready = 1'b1; s_oready = 1'b0; mem_hold = 1'b1;
    dut_fired.delete();
    step();
    check1("reset_out_valid", bus.out_valid, 1'b0);
    check32("reset_out_inst", bus.out_inst, 32'h0);
    check32("reset_out_pc", bus.out_pc, 32'h0);
    run(7);
    check32("credit_fires", 32'(dut_fired.size()), 32'd4);
    check_q("fire0", dut_fired, 0, 32'h0);
    check_q("fire1", dut_fired, 1, 32'h4);
    check_q("fire2", dut_fired, 2, 32'h8);
    check_q("fire3", dut_fired, 3, 32'hC);
    check1("credit_stop", bus.imem_req_valid, 1'b0);

    // Single-cycle memory streaming into a ready decoder
    mem_hold = 1'b0; mem_lat_max = 0; rsp_pct = 100; s_oready = 1'b1;
    dut_popped.delete();
    run(8);
    pops_seen = 0;
    run(6);
    check32("stream_no_gaps", 32'(pops_seen), 32'd6);
    check_q("pop0", dut_popped, 0, 32'h0);
    check_q("pop1", dut_popped, 1, 32'h4);
    check_q("pop2", dut_popped, 2, 32'h8);
    check32("pop0_inst", mem_word(32'h0), dut_popped.size() > 0 ? mem_word(dut_popped[0]) : 32'hX);

    // Decode backpressure for 6 cycles
    s_oready = 1'b0;
    step();
    frozen_pc = bus.out_pc;
    run(5);
    check32("head_frozen", bus.out_pc, frozen_pc);
    check1("full_no_req", bus.imem_req_valid, 1'b0);
    check1("full_out_valid", bus.out_valid, 1'b1);
    s_oready = 1'b1;
    run(10);

    // Redirect with 0x10 and 0x14 outstanding
    do_reset();
    s_redir = 1'b1; s_rpc = 32'h10; s_ready = 1'b1; mem_hold = 1'b1; s_oready = 1'b1;
    step();
    s_redir = 1'b0;
    run(2);
    s_ready = 1'b0;
    s_redir = 1'b1; s_rpc = 32'h100;
    step();
    s_redir = 1'b0; s_ready = 1'b1; mem_hold = 1'b0;
    dut_fired.delete(); dut_popped.delete();
    run(10);
    check_q("redir_first_req", dut_fired, 0, 32'h100);
    check_q("redir_first_pop", dut_popped, 0, 32'h100);

    // Redirect coinciding with a response and a would-be pop
    run(6);
    s_redir = 1'b1; s_rpc = 32'h200;
    step();
    check1("redir_out_valid", bus.out_valid, 1'b0);
    check1("redir_no_req", bus.imem_req_valid, 1'b0);
    s_redir = 1'b0;
    dut_popped.delete();
    run(8);
    check_q("redir2_first_pop", dut_popped, 0, 32'h200);

    // Fetch PC wraparound
    s_redir = 1'b1; s_rpc = 32'hFFFF_FFF8;
    step();
    s_redir = 1'b0;
    dut_popped.delete();
    run(10);
    check_q("wrap_pop0", dut_popped, 0, 32'hFFFF_FFF8);
    check_q("wrap_pop2", dut_popped, 2, 32'h0);

    // Reset with requests outstanding and entries queued
    do_reset();
    s_ready = 1'b1; s_oready = 1'b0; mem_hold = 1'b1;
    run(4);
    mem_hold = 1'b0;
    run(2);
    mem_hold = 1'b1;
    step();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0; mem_hold = 1'b0; s_oready = 1'b1;
    dut_fired.delete(); dut_popped.delete();
    step();
    check1("rst_mid_out_valid", bus.out_valid, 1'b0);
    check32("rst_mid_addr", bus.imem_req_addr, RPC);
    run(8);
    check_q("rst_mid_refetch", dut_fired, 0, RPC);
    check_q("rst_mid_first_pop", dut_popped, 0, RPC);

    // Randomized traffic
    for (int ep = 0; ep < 8; ep++) begin
      mem_lat_max = int'($urandom_range(3));
      rsp_pct     = 40 + int'($urandom_range(60));
      for (int i = 0; i < 500; i++) begin
        s_rst    = ($urandom_range(299) == 0);
        s_redir  = ($urandom_range(19) == 0);
        s_rpc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                            : ($urandom() & 32'hFFFF_FFFC);
        s_ready  = ($urandom_range(99) < 75);
        s_oready = ($urandom_range(99) < 70);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
